// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// one-entry skid buffer for stalled returns, and the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallFetch,
    input  logic        StallDecode,
    input  logic        FlushDecode,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pcf, pcf_nxt, pcf_plus4, target;
    logic [31:0] holdbuf, deliver_instr;
    logic        kill, kill_nxt;
    logic        accept, deliver, buf_load;

    assign accept    = !StallFetch && !StallDecode;
    assign target    = PCTargetE & 32'hFFFF_FFFC;
    assign pcf_plus4 = pcf + 32'd4;
    assign imem_addr = pcf;

    always_comb begin
        state_nxt     = state;
        pcf_nxt       = pcf;
        kill_nxt      = kill;
        deliver       = 1'b0;
        buf_load      = 1'b0;
        deliver_instr = imem_rdata;
        case (state)
            S_REQ: begin
                if (imem_req && imem_gnt) begin
                    state_nxt = S_WAIT;
                    // a redirect in the grant cycle orphans the request just accepted
                    kill_nxt  = PCSrcE;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill) begin
                        kill_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else if (PCSrcE) begin
                        state_nxt = S_REQ;
                    end else if (accept) begin
                        deliver   = 1'b1;
                        pcf_nxt   = pcf_plus4;
                        state_nxt = S_REQ;
                    end else begin
                        buf_load  = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end else if (PCSrcE) begin
                    kill_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    state_nxt = S_REQ;
                end else if (accept) begin
                    deliver       = 1'b1;
                    deliver_instr = holdbuf;
                    pcf_nxt       = pcf_plus4;
                    state_nxt     = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
        if (PCSrcE) pcf_nxt = target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pcf      <= RESET_PC & 32'hFFFF_FFFC;
            kill     <= 1'b0;
            holdbuf  <= '0;
            imem_req <= 1'b0;
        end else begin
            state    <= state_nxt;
            pcf      <= pcf_nxt;
            kill     <= kill_nxt;
            imem_req <= (state_nxt == S_REQ);
            if (buf_load) holdbuf <= imem_rdata;
        end
    end

    // Flush outranks both stall and delivery; an idle unstalled cycle inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushDecode) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallDecode) begin
            if (deliver) begin
                InstrD   <= deliver_instr;
                PCD      <= pcf;
                PCPlus4D <= pcf_plus4;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected IF/ID
// contents; an independent monitor pops and compares on each delivery.
module tb_fetch_unit;

    logic        clk, rst_n;
    logic        StallFetch, StallDecode, FlushDecode, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n),
        .StallFetch(StallFetch), .StallDecode(StallDecode), .FlushDecode(FlushDecode),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    logic sd_prev = 1'b0;

    // memory model controls
    int          mem_lat = 0;
    logic        ovr_en = 1'b0, stray = 1'b0;
    logic [31:0] ovr_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) sd_prev <= StallDecode;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.instr = i; e.pc = pc; e.pc4 = pc4;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string what);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ValidD && n < 20);
        if (!ValidD) begin
            vectors++;
            errors++;
            $display("FAIL %s: no delivery within %0d cycles", what, n);
        end
    endtask

    // Instruction memory: grant seen at negedge, data returned mem_lat cycles later.
    initial begin
        logic        g, pend;
        logic [31:0] a, paddr;
        int          dly;
        pend = 1'b0; paddr = '0; dly = 0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            g = imem_req && imem_gnt;
            a = imem_addr;
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (!rst_n) pend = 1'b0;
            if (g && rst_n) begin
                pend = 1'b1; paddr = a; dly = mem_lat;
            end
            if (pend) begin
                if (dly == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = ovr_en ? ovr_data : word(paddr);
                    ovr_en = 1'b0;
                    pend   = 1'b0;
                end else begin
                    dly--;
                end
            end else if (stray) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hBAD0_BAD0;
                stray = 1'b0;
            end
        end
    end

    // Monitor: a delivery is ValidD high after an edge where decode was not stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ValidD && !sd_prev) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_delivery: got pc %08h instr %08h expected none", PCD, InstrD);
                end else begin
                    e = sb.pop_front();
                    check("instrd", InstrD, e.instr);
                    check("pcd", PCD, e.pc);
                    check("pcplus4d", PCPlus4D, e.pc4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b1;
        StallFetch = 1'b0; StallDecode = 1'b0; FlushDecode = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0;
        repeat (3) step();

        check("rst_instrd", InstrD, 32'h0000_0013);
        check("rst_validd", 32'(ValidD), 32'd0);
        check("rst_pcd", PCD, 32'd0);
        check("rst_pcplus4d", PCPlus4D, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        rst_n = 1'b1;

        // sequential fetch
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'd0);
        push(32'h5A5A_0000, 32'h0000_0000, 32'h0000_0004);
        push(32'h5A5A_0004, 32'h0000_0004, 32'h0000_0008);
        push(32'h5A5A_0008, 32'h0000_0008, 32'h0000_000C);
        push(32'h5A5A_000C, 32'h0000_000C, 32'h0000_0010);
        for (int i = 0; i < 4; i++) wait_valid("seq");

        // load-use stall while the pc 16 word returns
        step();
        StallFetch = 1'b1; StallDecode = 1'b1;
        step();
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_instrd", InstrD, 32'h0000_0013);
        check("hold_pcd", PCD, 32'h0000_000C);
        step();
        check("hold2_req", 32'(imem_req), 32'd0);
        check("hold2_pcd", PCD, 32'h0000_000C);
        check("hold2_validd", 32'(ValidD), 32'd0);
        StallFetch = 1'b0; StallDecode = 1'b0;
        push(32'h5A5A_0010, 32'h0000_0010, 32'h0000_0014);
        step();
        check("release_validd", 32'(ValidD), 32'd1);
        check("release_pcd", PCD, 32'h0000_0010);

        // redirect while waiting; late data is discarded
        mem_lat = 1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0101;
        step();
        PCSrcE = 1'b0; mem_lat = 0;
        check("redir_wait_req", 32'(imem_req), 32'd0);
        step();
        check("redir_validd", 32'(ValidD), 32'd0);
        check("redir_instrd", InstrD, 32'h0000_0013);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        push(32'h5A5A_0100, 32'h0000_0100, 32'h0000_0104);
        wait_valid("redir");

        // flush together with stall
        FlushDecode = 1'b1; StallDecode = 1'b1;
        step();
        check("flush_instrd", InstrD, 32'h0000_0013);
        check("flush_validd", 32'(ValidD), 32'd0);
        check("flush_pcd", PCD, 32'h0000_0100);
        check("flush_pcplus4d", PCPlus4D, 32'h0000_0104);
        FlushDecode = 1'b0; StallDecode = 1'b0;
        push(32'h5A5A_0104, 32'h0000_0104, 32'h0000_0108);
        wait_valid("flush");

        // redirect in the grant cycle to the top of the address space
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
        step();
        PCSrcE = 1'b0;
        check("kill_req", 32'(imem_req), 32'd0);
        step();
        check("kill_validd", 32'(ValidD), 32'd0);
        check("kill_addr", imem_addr, 32'hFFFF_FFFC);
        push(32'hA5A5_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
        push(32'h5A5A_0000, 32'h0000_0000, 32'h0000_0004);
        wait_valid("wrap");
        check("wrap_pcplus4d", PCPlus4D, 32'h0000_0000);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        wait_valid("wrap_next");

        // reset while a request is outstanding
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_instrd", InstrD, 32'h0000_0013);
        check("mid_rst_validd", 32'(ValidD), 32'd0);
        check("mid_rst_pcd", PCD, 32'd0);
        check("mid_rst_pcplus4d", PCPlus4D, 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        stray = 1'b1; imem_gnt = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'd0);
        check("post_rst_validd", 32'(ValidD), 32'd0);
        step();
        check("nogrant_req", 32'(imem_req), 32'd1);
        check("nogrant_addr", imem_addr, 32'd0);
        imem_gnt = 1'b1;
        push(32'h5A5A_0000, 32'h0000_0000, 32'h0000_0004);
        wait_valid("post_rst");
        imem_gnt = 1'b0;

        repeat (4) step();
        check("drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction word driven on InstrD for a bubble.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 StallFetch  input  1  SHALL block delivery of a new instruction and PCF advance.
REQ-006 StallDecode  input  1  SHALL hold the IF/ID outputs.
REQ-007 FlushDecode  input  1  SHALL turn the IF/ID outputs into a bubble.
REQ-008 PCSrcE  input  1  SHALL signal a taken branch or jump resolved in execute.
REQ-009 PCTargetE  input  32  SHALL be the redirect target.
REQ-010 imem_req  output  1  SHALL request an instruction fetch.
REQ-011 imem_addr  output  32  SHALL carry the fetch address, equal to PCF.
REQ-012 imem_gnt  input  1  SHALL accept the request in the cycle it is high with imem_req.
REQ-013 imem_rvalid  input  1  SHALL mark imem_rdata valid, at least 1 cycle after grant.
REQ-014 imem_rdata  input  32  SHALL carry the fetched instruction.
REQ-015 InstrD, PCD, PCPlus4D  output  32 each  SHALL be the IF/ID register: instruction, its PC, and PC+4.
REQ-016 ValidD  output  1  SHALL be high when InstrD holds a real instruction.

Function
REQ-017 State machine SHALL have states REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-018 In REQ, the block SHALL drive imem_req=1 and imem_addr=PCF; on imem_gnt the next state SHALL be WAIT.
REQ-019 In WAIT and HOLD, imem_req SHALL be 0.
REQ-020 In WAIT, when imem_rvalid=1, kill=0 and accept=1 (accept = !StallFetch && !StallDecode), the block SHALL load InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4 and ValidD=1, set PCF<=PCF+4, and go to REQ.
REQ-021 In WAIT, when imem_rvalid=1, kill=0 and accept=0, the block SHALL store imem_rdata in a one-entry buffer and go to HOLD.
REQ-022 In HOLD with accept=1, the block SHALL load the IF/ID register from the buffer (PCD=PCF), set PCF<=PCF+4, and go to REQ.
REQ-023 Whenever StallDecode=0 and no instruction is delivered in that cycle, the IF/ID register SHALL load a bubble: InstrD=NOP_INSTR, ValidD=0, PCD and PCPlus4D unchanged.
REQ-024 With StallDecode=1 and FlushDecode=0, all IF/ID outputs SHALL hold their values.
REQ-025 FlushDecode=1 SHALL load a bubble into IF/ID, with priority over StallDecode and over delivery.
REQ-026 On PCSrcE=1, the block SHALL set PCF<=PCTargetE, with priority over any +4 update.
REQ-027 On PCSrcE=1 in REQ, the block SHALL go to WAIT with kill=1 if granted that cycle, else stay in REQ.
REQ-028 On PCSrcE=1 in WAIT without imem_rvalid, the block SHALL set kill=1.
REQ-029 On PCSrcE=1 in WAIT with imem_rvalid, or in HOLD, the block SHALL drop the data or buffer and go to REQ.
REQ-030 In WAIT with kill=1, imem_rvalid SHALL discard the data, clear kill, deliver nothing, and go to REQ.
REQ-031 In a kill-discard cycle, a simultaneous PCSrcE SHALL still update PCF.
REQ-032 PCF and PCPlus4D arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-033 PCF[1:0] SHALL always be 2'b00; PCTargetE[1:0] SHALL be ignored and forced to 0.

Reset
REQ-034 While rst_n=0, outputs SHALL be: state REQ, PCF=RESET_PC, kill=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, imem_req=0.
REQ-035 imem_req SHALL go high on the first clock edge after rst_n deasserts.
REQ-036 Reset asserted mid-operation SHALL abandon any outstanding request.
REQ-037 imem_rvalid SHALL be ignored until the block has issued a request after reset.

Verification
REQ-038 Sequential fetch: grant every REQ cycle, rvalid 1 cycle after grant, no stalls -> ValidD sequence with PCD=0,4,8,...; one instruction every 2 cycles.
REQ-039 Load-use stall: StallFetch=StallDecode=1 for 2 cycles while rvalid arrives -> state HOLD; InstrD/PCD unchanged; buffered word delivered on the first cycle after stall release.
REQ-040 Redirect during WAIT: PCSrcE=1 with PCTargetE=32'h100, then rvalid returns 32'hDEAD_BEEF -> word discarded, ValidD=0, next imem_addr=32'h100.
REQ-041 Flush with stall: FlushDecode=1 and StallDecode=1 in the same cycle -> InstrD=32'h0000_0013, ValidD=0.
REQ-042 Wrap: PCF=32'hFFFF_FFFC delivered -> PCPlus4D=0; next imem_addr=0.
REQ-043 Reset in WAIT: rst_n pulsed low -> outputs at reset values immediately; later stray rvalid ignored; first request addresses RESET_PC.
